// File: rtl/lut_segment_fetcher.sv
// lut_segment_fetcher
// Front end of the piecewise-linear activation path. A signed sample x is split
// into a table index (offset binary upper bits) and a fraction (lower bits). The
// two bracketing entries are read from an internal 16-entry table through a
// single registered read port. They are then presented with the fraction to the
// downstream interpolator under a valid/ready handshake. The table is loaded
// through a write port that is open only while the block is idle.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   x          in   signed input sample
//   in_valid   in   x valid
//   in_ready   out  block can accept x (IDLE only)
//   remaining  out  zero-extended fraction of x
//   base       out  table[addr]
//   next_data  out  table[addr+1], clamped at the last entry
//   out_valid  out  outputs valid
//   out_ready  in   downstream accepts
//   wr_en      in   table write request
//   wr_addr    in   table write address
//   wr_data    in   table write data
//   wr_ready   out  a write is accepted this cycle
module lut_segment_fetcher #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FRAC_W = 4,
    parameter int unsigned IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] remaining,
    output logic [DATA_W-1:0] base,
    output logic [DATA_W-1:0] next_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_BASE = 3'd1;
    localparam logic [2:0] S_RD_NEXT = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;

    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_table [DEPTH];

    logic [IDX_W-1:0]  w_addr;
    logic [IDX_W-1:0]  w_naddr;
    logic              w_idle;

    // Inverting the sign bit maps -128..127 onto addresses 0..15 in order.
    assign w_addr  = {~r_x[DATA_W-1], r_x[DATA_W-2:FRAC_W]};
    // The top segment has no successor, so it brackets against itself.
    assign w_naddr = (w_addr == {IDX_W{1'b1}}) ? w_addr : w_addr + IDX_W'(1);

    assign w_idle   = (r_state == S_IDLE);
    assign in_ready = w_idle;
    assign wr_ready = w_idle && !rst;

    // Table storage; writes only land while idle, so a write accepted together
    // with a sample is visible to that sample's first read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else if (wr_en && wr_ready) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_rd_data <= '0;
            remaining <= '0;
            base      <= '0;
            next_data <= '0;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x     <= x;
                        r_state <= S_RD_BASE;
                    end
                end
                S_RD_BASE: begin
                    r_rd_data <= r_table[w_addr];
                    r_state   <= S_RD_NEXT;
                end
                S_RD_NEXT: begin
                    base      <= r_rd_data;
                    r_rd_data <= r_table[w_naddr];
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    next_data <= r_rd_data;
                    remaining <= {{(DATA_W - FRAC_W){1'b0}}, r_x[FRAC_W-1:0]};
                    out_valid <= 1'b1;
                    r_state   <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_segment_fetcher.sv
module tb_lut_segment_fetcher;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] x;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] remaining;
    logic [7:0] base;
    logic [7:0] next_data;
    logic       out_valid;
    logic       out_ready;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;

    int errors = 0;
    int checks = 0;

    lut_segment_fetcher #(
        .DATA_W(8),
        .FRAC_W(4),
        .IDX_W (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .remaining(remaining),
        .base     (base),
        .next_data(next_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present x in IDLE, then verify the 4-cycle latency and the result.
    task automatic fetch(input string tag, input logic [7:0] xv,
                         input logic [7:0] eb, input logic [7:0] en, input logic [7:0] er);
        x        = xv;
        in_valid = 1'b1;
        check({tag, ".in_ready_idle"}, {7'd0, in_ready}, 8'd1);
        tick();
        in_valid = 1'b0;
        wr_en    = 1'b0;
        check({tag, ".in_ready_busy"}, {7'd0, in_ready}, 8'd0);
        tick();
        tick();
        check({tag, ".out_valid_early"}, {7'd0, out_valid}, 8'd0);
        tick();
        check({tag, ".out_valid"}, {7'd0, out_valid}, 8'd1);
        check({tag, ".base"}, base, eb);
        check({tag, ".next_data"}, next_data, en);
        check({tag, ".remaining"}, remaining, er);
    endtask

    // Complete the output handshake; outputs must persist afterwards.
    task automatic handshake(input string tag, input logic [7:0] eb);
        out_ready = 1'b1;
        tick();
        check({tag, ".hs_out_valid"}, {7'd0, out_valid}, 8'd0);
        check({tag, ".hs_in_ready"}, {7'd0, in_ready}, 8'd1);
        check({tag, ".hs_base_kept"}, base, eb);
    endtask

    initial begin
        rst       = 1'b1;
        x         = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = 4'd0;
        wr_data   = 8'h00;
        tick();
        tick();
        check("rst.wr_ready", {7'd0, wr_ready}, 8'd0);
        check("rst.out_valid", {7'd0, out_valid}, 8'd0);
        check("rst.in_ready", {7'd0, in_ready}, 8'd1);
        check("rst.base", base, 8'h00);
        check("rst.next_data", next_data, 8'h00);
        check("rst.remaining", remaining, 8'h00);
        rst = 1'b0;
        #1;
        check("idle.wr_ready", {7'd0, wr_ready}, 8'd1);

        // table[k] = 8k - 64
        for (int k = 0; k < 16; k++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(k);
            wr_data = 8'(8 * k - 64);
            tick();
        end
        wr_en = 1'b0;

        fetch("x00", 8'h00, 8'h00, 8'h08, 8'd0);
        handshake("x00", 8'h00);
        fetch("x25", 8'h25, 8'h10, 8'h18, 8'd5);
        handshake("x25", 8'h10);
        fetch("xDB", 8'hDB, 8'hE8, 8'hF0, 8'd11);
        handshake("xDB", 8'hE8);
        fetch("x7F", 8'h7F, 8'h38, 8'h38, 8'd15);
        handshake("x7F", 8'h38);
        fetch("x80", 8'h80, 8'hC0, 8'hC8, 8'd0);
        handshake("x80", 8'hC0);

        // Backpressure: a pending sample must wait for the handshake.
        out_ready = 1'b0;
        fetch("bp", 8'h00, 8'h00, 8'h08, 8'd0);
        x        = 8'h25;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bp.out_valid", {7'd0, out_valid}, 8'd1);
            check("bp.in_ready", {7'd0, in_ready}, 8'd0);
            check("bp.base", base, 8'h00);
            check("bp.next_data", next_data, 8'h08);
            check("bp.remaining", remaining, 8'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp.hs_out_valid", {7'd0, out_valid}, 8'd0);
        check("bp.hs_in_ready", {7'd0, in_ready}, 8'd1);
        fetch("bp_next", 8'h25, 8'h10, 8'h18, 8'd5);
        handshake("bp_next", 8'h10);

        // Write issued in RD_NEXT is ignored.
        x        = 8'h25;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        wr_en   = 1'b1;
        wr_addr = 4'd10;
        wr_data = 8'h11;
        check("busy.wr_ready", {7'd0, wr_ready}, 8'd0);
        tick();
        wr_en = 1'b0;
        tick();
        check("busy.base", base, 8'h10);
        handshake("busy", 8'h10);
        fetch("reread10", 8'h25, 8'h10, 8'h18, 8'd5);
        handshake("reread10", 8'h10);

        // Write together with the accept is seen by that fetch.
        wr_en   = 1'b1;
        wr_addr = 4'd10;
        wr_data = 8'h11;
        fetch("wr_idle", 8'h20, 8'h11, 8'h18, 8'd0);
        handshake("wr_idle", 8'h11);

        // Reset during RD_NEXT aborts the fetch and clears the table.
        x        = 8'h5A;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.out_valid", {7'd0, out_valid}, 8'd0);
        check("abort.in_ready", {7'd0, in_ready}, 8'd1);
        check("abort.base", base, 8'h00);
        check("abort.next_data", next_data, 8'h00);
        check("abort.remaining", remaining, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort.no_output", {7'd0, out_valid}, 8'd0);
        end
        fetch("clr_lo", 8'h00, 8'h00, 8'h00, 8'd0);
        handshake("clr_lo", 8'h00);
        fetch("clr_hi", 8'h7F, 8'h00, 8'h00, 8'd15);
        handshake("clr_hi", 8'h00);
        fetch("clr_a10", 8'h25, 8'h00, 8'h00, 8'd5);
        handshake("clr_a10", 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lut_segment_fetcher.md
Name: lut_segment_fetcher

Overview:
- Front end of the piecewise-linear activation path in each layer function.
- Accepts a signed 8-bit pre-activation x and splits it into a segment index and a 4-bit fraction.
- Reads the two bracketing entries from an internal 16-entry table, then presents remaining, base and next_data to the downstream interpolator under a valid/ready handshake.
- Also owns the table-load write port.

Parameters:
- DATA_W, 8, width of x, table entries, base, next_data and remaining.
- FRAC_W, 4, fraction bits of x; must equal the interpolator shift amount.
- IDX_W, 4, index bits; table depth = 2^IDX_W; DATA_W = IDX_W + FRAC_W.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- x  in  DATA_W  signed input sample
- in_valid  in  1  x valid
- in_ready  out  1  block can accept x
- remaining  out  DATA_W  signed, zero-extended fraction
- base  out  DATA_W  signed table[addr]
- next_data  out  DATA_W  signed table[addr+1], clamped
- out_valid  out  1  outputs valid
- out_ready  in  1  downstream accepts
- wr_en  in  1  table write request
- wr_addr  in  IDX_W  table write address
- wr_data  in  DATA_W  table write data
- wr_ready  out  1  write will be accepted this cycle

Behaviour:
- Reset, synchronous and active-high as decided: state=IDLE; in_ready=1; out_valid=0; remaining, base and next_data = 0; all table entries = 0. rst asserted mid-operation aborts the fetch and discards the latched sample and partial data.
- Address mapping: addr = {~x[DATA_W-1], x[DATA_W-2:FRAC_W]} (offset binary; x=-128 gives addr 0, x=0 gives addr 8).
- remaining = zero-extended x[FRAC_W-1:0], range 0..15.
- naddr = addr+1, except addr = 2^IDX_W-1 gives naddr = addr, so next_data = base (no wrap).
- Table read model: single registered read port, one entry per cycle.
- FSM states:
  - IDLE: in_ready=1, wr_ready=1. If in_valid, latch x and go to RD_BASE.
  - RD_BASE: issue read of addr; go to RD_NEXT.
  - RD_NEXT: capture base; issue read of naddr; go to DONE.
  - DONE: capture next_data; drive remaining; set out_valid=1; go to HOLD.
  - HOLD: hold all outputs stable while out_ready=0. On out_valid & out_ready, clear out_valid and go to IDLE.
- Latency: handshake in cycle N gives out_valid=1 in cycle N+4. Minimum issue interval is 5 cycles. in_ready=0 in every state except IDLE.
- Outputs keep their last values after the handshake; only out_valid drops.
- Writes: accepted only when wr_ready=1, i.e. state IDLE and not rst. In IDLE, a write and an in_valid accept may occur in the same cycle; the write is committed before RD_BASE, so the read sees the new data. wr_en outside IDLE is ignored with no side effect.
- Arithmetic: no arithmetic beyond the 4-bit index increment with clamp. All outputs are plain registers.

Test Plan:
- Load table[k]=8k-64 for k=0..15 via the write port. Send x=0x00 -> 4 cycles later: base=0, next_data=8, remaining=0, out_valid=1.
- x=0x25 -> addr 10: base=16, next_data=24, remaining=5. x=0xDB (-37) -> addr 5: base=-24, next_data=-16, remaining=11.
- Boundaries: x=0x7F -> base=56, next_data=56 (clamp), remaining=15. x=0x80 -> base=-64, next_data=-56, remaining=0.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid. Outputs stay stable, in_ready=0, and a new in_valid is not accepted. Release -> accepted exactly 1 cycle after the handshake.
- In RD_NEXT, pulse wr_en to addr 10 with 0x11 -> ignored. A later read of addr 10 returns 16. The same write issued in IDLE together with in_valid x=0x20 -> base=0x11.
- Assert rst during RD_NEXT -> next cycle: out_valid=0, in_ready=1, all outputs 0, table all 0. The aborted sample never appears.
